// File: rtl/scaled_frame_fetch.sv
// Streams a replicated SRC_W x SRC_H image from a 1-cycle ROM into a pixel FIFO,
// repeating pixels HSCALE times per line and lines VSCALE times per frame.
module scaled_frame_fetch #(
  parameter int DATA_W = 24,
  parameter int SRC_W  = 80,
  parameter int SRC_H  = 60,
  parameter int HSCALE = 8,
  parameter int VSCALE = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_sof,
  output logic              fifo_eol,
  output logic              fifo_wr,
  input  logic              fifo_afull,
  input  logic              fifo_empty,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = (SRC_W  > 1) ? $clog2(SRC_W)  : 1;
  localparam int RW = (SRC_H  > 1) ? $clog2(SRC_H)  : 1;
  localparam int HW = (HSCALE > 1) ? $clog2(HSCALE) : 1;
  localparam int VW = (VSCALE > 1) ? $clog2(VSCALE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [HW-1:0]     hrep_q, hrep_d;
  logic [VW-1:0]     vrep_q, vrep_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_q, sof_q, eol_q, done_q;

  logic hwrap, cwrap, vwrap, rwrap;
  logic sof_tag, eol_tag, last_tag;

  assign hwrap = (hrep_q == HW'(HSCALE-1));
  assign cwrap = (col_q  == CW'(SRC_W-1));
  assign vwrap = (vrep_q == VW'(VSCALE-1));
  assign rwrap = (row_q  == RW'(SRC_H-1));

  assign sof_tag  = (col_q == '0) && (hrep_q == '0) &&
                    (row_q == '0) && (vrep_q == '0);
  assign eol_tag  = cwrap && hwrap;
  assign last_tag = eol_tag && vwrap && rwrap;

  // afull gates the strobe combinationally so no read lands without a slot
  assign rom_rd   = (state_q == FILL) && !fifo_afull;
  assign rom_addr = base_q + ADDR_W'(col_q);

  assign fifo_wr    = wr_q;
  assign fifo_sof   = sof_q;
  assign fifo_eol   = eol_q;
  assign frame_done = done_q;
  assign fifo_wdata = wr_q ? rom_rdata : '0;
  assign busy       = (state_q != IDLE);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hrep_d = hrep_q;
    vrep_d = vrep_q;
    base_d = base_q;
    if (rom_rd) begin
      if (!hwrap) begin
        hrep_d = hrep_q + 1'b1;
      end else begin
        hrep_d = '0;
        if (!cwrap) begin
          col_d = col_q + 1'b1;
        end else begin
          col_d = '0;
          if (!vwrap) begin
            vrep_d = vrep_q + 1'b1;
          end else begin
            vrep_d = '0;
            if (!rwrap) begin
              row_d  = row_q + 1'b1;
              base_d = base_q + ADDR_W'(SRC_W);
            end else begin
              row_d  = '0;
              base_d = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      hrep_q  <= '0;
      vrep_q  <= '0;
      base_q  <= '0;
      wr_q    <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hrep_q <= hrep_d;
      vrep_q <= vrep_d;
      base_q <= base_d;
      wr_q   <= rom_rd;
      sof_q  <= rom_rd && sof_tag;
      eol_q  <= rom_rd && eol_tag;
      done_q <= rom_rd && last_tag;
      unique case (state_q)
        IDLE: if (en) state_q <= FILL;
        FILL: begin
          if (rom_rd && last_tag && !en) state_q <= IDLE;
          else if (fifo_afull)           state_q <= WAIT;
        end
        WAIT: begin
          // parked exactly on a frame boundary: en may still stop us here
          if (sof_tag && !en)   state_q <= IDLE;
          else if (fifo_empty)  state_q <= FILL;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scaled_frame_fetch.sv
// Directed bench for scaled_frame_fetch: a 4x2 x2x2 instance for flow control,
// enable and reset behaviour, plus a 4x3 x1x1 instance for the degenerate scale.
module tb_scaled_frame_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, afull, empty;
  logic [3:0]  rom_addr;
  logic        rom_rd;
  logic [23:0] rom_rdata, fifo_wdata;
  logic        fifo_sof, fifo_eol, fifo_wr, frame_done, busy;

  logic        rst2, en2;
  logic [3:0]  rom_addr2;
  logic        rom_rd2;
  logic [23:0] rom_rdata2, fifo_wdata2;
  logic        sof2, eol2, wr2, done2, busy2;

  scaled_frame_fetch #(
    .DATA_W(24), .SRC_W(4), .SRC_H(2),
    .HSCALE(2), .VSCALE(2), .ADDR_W(4)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_rdata(rom_rdata),
    .fifo_wdata(fifo_wdata), .fifo_sof(fifo_sof), .fifo_eol(fifo_eol),
    .fifo_wr(fifo_wr), .fifo_afull(afull), .fifo_empty(empty),
    .frame_done(frame_done), .busy(busy)
  );

  scaled_frame_fetch #(
    .DATA_W(24), .SRC_W(4), .SRC_H(3),
    .HSCALE(1), .VSCALE(1), .ADDR_W(4)
  ) u_dut1 (
    .clk(clk), .rst(rst2), .en(en2),
    .rom_addr(rom_addr2), .rom_rd(rom_rd2), .rom_rdata(rom_rdata2),
    .fifo_wdata(fifo_wdata2), .fifo_sof(sof2), .fifo_eol(eol2),
    .fifo_wr(wr2), .fifo_afull(1'b0), .fifo_empty(1'b0),
    .frame_done(done2), .busy(busy2)
  );

  // ROM models: 1-cycle registered read, content tagged with the address
  always @(posedge clk) if (rom_rd)  rom_rdata  <= 24'hA50000 | 24'(rom_addr);
  always @(posedge clk) if (rom_rd2) rom_rdata2 <= 24'hB60000 | 24'(rom_addr2);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 4x2 image, x2 horizontally and vertically: 8 words per line, 32 per frame
  function automatic logic [31:0] exp_addr(input int n);
    int k;
    k = n % 32;
    return 32'(((k / 8) / 2) * 4 + (k % 8) / 2);
  endfunction

  int rcnt, wcnt, done_cnt;
  always @(negedge clk) begin
    if (rst) begin
      rcnt = 0;
      wcnt = 0;
      done_cnt = 0;
    end else begin
      if (rom_rd) begin
        chk("rd_addr", 32'(rom_addr), exp_addr(rcnt));
        if (afull) chk("rd_afull", 1, 0);
        rcnt++;
      end
      if (fifo_wr) begin
        chk("wdata", 32'(fifo_wdata), 32'h00A50000 | exp_addr(wcnt));
        chk("sof", 32'(fifo_sof), 32'(wcnt % 32 == 0));
        chk("eol", 32'(fifo_eol), 32'(wcnt % 8 == 7));
        chk("done", 32'(frame_done), 32'(wcnt % 32 == 31));
        wcnt++;
      end else if (frame_done || fifo_sof || fifo_eol) begin
        chk("tag_no_wr", 1, 0);
      end
      if (frame_done) done_cnt++;
    end
  end

  int rc2, wc2, dc2;
  always @(negedge clk) begin
    if (rst2) begin
      rc2 = 0;
      wc2 = 0;
      dc2 = 0;
    end else begin
      if (rom_rd2) begin
        chk("b_addr", 32'(rom_addr2), 32'(rc2 % 12));
        rc2++;
      end
      if (wr2) begin
        chk("b_wdata", 32'(fifo_wdata2), 32'h00B60000 | 32'(wc2 % 12));
        chk("b_sof", 32'(sof2), 32'(wc2 % 12 == 0));
        chk("b_eol", 32'(eol2), 32'(wc2 % 4 == 3));
        chk("b_done", 32'(done2), 32'(wc2 % 12 == 11));
        wc2++;
      end
      if (done2) dc2++;
    end
  end

  task automatic wait_w(input int t, input int budget);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (wcnt < t && k < budget);
    #1;
    if (wcnt < t) chk("timeout_w", 32'(wcnt), 32'(t));
  endtask

  task automatic wait_r(input int t, input int budget);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (rcnt < t && k < budget);
    #1;
    if (rcnt < t) chk("timeout_r", 32'(rcnt), 32'(t));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    afull = 1'b0;
    empty = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst2 = 1'b1;
    en2 = 1'b0;
    rst = 1'b1;
    en = 1'b0;
    afull = 1'b0;
    empty = 1'b0;
    @(negedge clk);
    chk("rst_wr", 32'(fifo_wr), 0);
    chk("rst_rd", 32'(rom_rd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_wdata", 32'(fifo_wdata), 0);
    chk("rst_done", 32'(frame_done), 0);

    // 1: free-running frame and wrap into the next one
    do_reset();
    en = 1'b1;
    wait_w(33, 80);
    chk("t1_done_cnt", 32'(done_cnt), 1);

    // 2: afull after word 5, hysteresis, degenerate afull+empty
    do_reset();
    en = 1'b1;
    wait_r(6, 20);
    afull = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t2_afull_rd", 32'(rom_rd), 0);
    end
    chk("t2_wr_after", 32'(wcnt), 6);
    chk("t2_rd_after", 32'(rcnt), 6);
    @(posedge clk);
    #1 afull = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_wait_rd", 32'(rom_rd), 0);
    end
    @(posedge clk);
    #1 afull = 1'b1;
    empty = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t2_both_rd", 32'(rom_rd), 0);
    end
    @(posedge clk);
    #1 afull = 1'b0;
    repeat (2) @(posedge clk);
    #1 empty = 1'b0;
    wait_w(32, 60);
    chk("t2_done_cnt", 32'(done_cnt), 1);

    // 3: en dropped mid-frame
    do_reset();
    en = 1'b1;
    wait_w(10, 40);
    en = 1'b0;
    wait_w(32, 60);
    chk("t3_done_cnt", 32'(done_cnt), 1);
    repeat (4) begin
      @(negedge clk);
      chk("t3_busy", 32'(busy), 0);
      chk("t3_rd", 32'(rom_rd), 0);
    end
    chk("t3_rcnt", 32'(rcnt), 32);
    @(posedge clk);
    #1 en = 1'b1;
    wait_w(33, 20);

    // 4: reset pulse mid-frame
    do_reset();
    en = 1'b1;
    wait_w(13, 40);
    chk("t4_pre_wr", 32'(fifo_wr), 1);
    rst = 1'b1;
    #1;
    chk("t4_wr", 32'(fifo_wr), 0);
    chk("t4_rd", 32'(rom_rd), 0);
    chk("t4_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_w(2, 20);

    // 5: unit scale, linear addresses 0..11 then wrap
    rst2 = 1'b0;
    en2 = 1'b1;
    begin
      int k = 0;
      while (wc2 < 14 && k < 40) begin
        @(posedge clk);
        k++;
      end
      #1;
      if (wc2 < 14) chk("timeout_b", 32'(wc2), 14);
    end
    chk("t5_done_cnt", 32'(dc2), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
